byte_unstriper: RTL and testbench
=================================

BYTE_UNSTRIPER -- requirements
Module: byte_unstriper

Interface
REQ-001 The block SHALL have parameter COM, default 8'hBC, the comma/idle character used for alignment and fill.
REQ-002 The block SHALL have parameter SYNC_COUNT, default 4, the number of consecutive valid COM bytes required to achieve sync (range 1-15).
REQ-003 The block SHALL have parameter TIMEOUT, default 8, the idle-cycle limit for partial-word flush (range 2-15; used only with the macro in REQ-024).
REQ-004 The block SHALL have port clk_f, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, 8 bits: the incoming byte stream.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is meaningful this cycle.
REQ-008 The block SHALL have ports data_0p, data_1p, data_2p, data_3p, each output, 8 bits: the lane bytes of the last completed word.
REQ-009 The block SHALL have ports valid_0p, valid_1p, valid_2p, valid_3p, each output, 1 bit: the per-lane word-completion strobes.
REQ-010 The block SHALL have port active, output, 1 bit: high while the block is in the SYNCED state.

Function
REQ-011 The FSM SHALL have exactly two states, SEARCH and SYNCED, and SHALL enter SEARCH on reset.
REQ-012 In SEARCH, the block SHALL count consecutive valid COM bytes: valid non-COM clears the count; valid_in=0 holds it.
REQ-013 In SEARCH, the edge that samples the SYNC_COUNT-th COM SHALL move the FSM to SYNCED and set slot pointer to 0; active SHALL be 1 from the following cycle.
REQ-014 In SYNCED, a valid COM byte at slot 0 SHALL be discarded as idle fill, with slot and outputs unchanged.
REQ-015 In SYNCED, any valid byte at slots 1-3, or a valid non-COM byte at slot 0, SHALL be captured into lane[slot], and slot SHALL increment.
REQ-016 In SYNCED, valid_in=0 SHALL leave slot and the holding registers unchanged.
REQ-017 On the edge that captures the slot-3 byte, the block SHALL load data_0p..data_3p with lanes 0-3 (lane 3 = data_in that edge), assert valid_0p..valid_3p, and wrap slot to 0.
REQ-018 valid_xp SHALL be single-cycle pulses, deasserted at the next edge.
REQ-019 data_xp SHALL hold their values until the next word completion or flush.
REQ-020 Word latency SHALL be 1 cycle: outputs are visible in the cycle after the 4th byte is sampled.
REQ-021 Once SYNCED, the block SHALL leave that state only via reset.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for a clock edge, set all of the following: data_0p..data_3p=8'h00; valid_0p..valid_3p=0; active=0; state=SEARCH; slot=0; sync count=0; holding registers=0; idle counter=0.
REQ-023 Reset asserted mid-word SHALL discard the partial word with no valid pulse; after release, the block SHALL require a full SYNC_COUNT COM sequence again.

Configuration
REQ-024 When macro UNSTRIPE_TIMEOUT_EN is defined, the block SHALL, in SYNCED with slot!=0, count consecutive valid_in=0 cycles; any valid byte SHALL clear the count.
REQ-025 With UNSTRIPE_TIMEOUT_EN defined, on the edge where the count reaches TIMEOUT, the block SHALL flush the partial word as follows:
- captured lanes load data_xp with valid_xp=1;
- uncaptured lanes load 8'h00 with valid_xp=0;
- slot and the count reset to 0.
REQ-026 Without UNSTRIPE_TIMEOUT_EN, the block SHALL have no idle counter and SHALL hold a partial word indefinitely until it completes.

Verification
REQ-027 Sync and word: the bench SHALL drive reset pulse, 4x valid BC, then valid 11,22,33,44 -> required: active=1 after the 4th BC; one cycle later than 44 is sampled, data_0p..3p=11,22,33,44 with all valid_xp=1 for exactly 1 cycle.
REQ-028 Broken sync: the bench SHALL drive BC,BC,BC,7E,BC,BC,BC -> required: active stays 0; one more BC -> active=1.
REQ-029 Idle and gaps: the bench SHALL drive, once SYNCED, BC,BC (slot 0), then AA, gap 3 cycles, BC, CC, DD -> required: word AA,BC,CC,DD; the slot-0 BCs are dropped and the BC at slot 1 is kept.
REQ-030 Reset mid-word: the bench SHALL assert reset asynchronously (between edges) after AA,BB are captured -> required: outputs zero immediately, no valid pulse, and active=0 until 4 new BC.
REQ-031 Timeout (UNSTRIPE_TIMEOUT_EN only): the bench SHALL drive AA,BB, then 8 idle cycles -> required: data=AA,BB,00,00, valid=1,1,0,0 for 1 cycle; the next EE,FF,01,02 forms a normal word. Without the macro, the bench SHALL verify no pulse, and that CC,DD later completes AA,BB,CC,DD.

Source files
------------

// File: rtl/byte_unstriper.sv
// Byte unstriper: aligns on a run of COM characters, then reassembles four
// consecutive bytes into one lane word. Optional partial-word flush: UNSTRIPE_TIMEOUT_EN.

module byte_unstriper_lane (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       cap_en,
  input  logic [7:0] cap_data,
  input  logic       out_load,
  input  logic       out_keep,
  output logic [7:0] data_p,
  output logic       valid_p
);
  logic [7:0] hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (cap_en) hold_d = cap_data;
    // The last lane is captured on the same edge the word is published.
    if (out_load) begin
      data_d  = out_keep ? (cap_en ? cap_data : hold_q) : 8'h00;
      valid_d = out_keep;
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      hold_q  <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_p  = data_q;
  assign valid_p = valid_q;
endmodule

module byte_unstriper #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         TIMEOUT    = 8
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_0p,
  output logic [7:0] data_1p,
  output logic [7:0] data_2p,
  output logic [7:0] data_3p,
  output logic       valid_0p,
  output logic       valid_1p,
  output logic       valid_2p,
  output logic       valid_3p,
  output logic       active
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  if (SYNC_COUNT < 1 || SYNC_COUNT > 15 || TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_param
    $error("byte_unstriper: SYNC_COUNT or TIMEOUT out of range");
  end

  typedef enum logic {SEARCH = 1'b0, SYNCED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       active_q, active_d;
  logic       take, complete, flush, out_load;
  logic [NUM_LANES-1:0]      cap_en, out_keep, valid_p;
  logic [NUM_LANES-1:0][7:0] data_p;

`ifdef UNSTRIPE_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  logic [3:0] idle_cnt_q, idle_cnt_d;

  // Only idle cycles with a partially filled word count toward a flush.
  always_comb begin
    idle_cnt_d = 4'd0;
    flush      = 1'b0;
    if (state_q == SYNCED && slot_q != 2'd0 && !valid_in) begin
      if (idle_cnt_q == TO_LAST) flush = 1'b1;
      else                       idle_cnt_d = idle_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) idle_cnt_q <= 4'd0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sync_cnt_d = sync_cnt_q;
    take       = 1'b0;
    complete   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (valid_in) begin
          if (data_in == COM) begin
            if (sync_cnt_q == SYNC_LAST) begin
              state_d    = SYNCED;
              slot_d     = 2'd0;
              sync_cnt_d = 4'd0;
            end else begin
              sync_cnt_d = sync_cnt_q + 4'd1;
            end
          end else begin
            sync_cnt_d = 4'd0;
          end
        end
      end
      SYNCED: begin
        // COM at a word boundary is idle fill; inside a word it is payload.
        take     = valid_in && !(slot_q == 2'd0 && data_in == COM);
        complete = take && slot_q == 2'd3;
        if (take)       slot_d = slot_q + 2'd1;
        else if (flush) slot_d = 2'd0;
      end
      default: state_d = SEARCH;
    endcase
    active_d = (state_d == SYNCED);
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      slot_q     <= 2'd0;
      sync_cnt_q <= 4'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sync_cnt_q <= sync_cnt_d;
      active_q   <= active_d;
    end
  end

  assign out_load = complete | flush;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign cap_en[i]   = take && (slot_q == 2'(i));
    assign out_keep[i] = complete || (slot_q > 2'(i));
    byte_unstriper_lane u_lane (
      .clk_f    (clk_f),
      .reset    (reset),
      .cap_en   (cap_en[i]),
      .cap_data (data_in),
      .out_load (out_load),
      .out_keep (out_keep[i]),
      .data_p   (data_p[i]),
      .valid_p  (valid_p[i])
    );
  end

  assign data_0p  = data_p[0];
  assign data_1p  = data_p[1];
  assign data_2p  = data_p[2];
  assign data_3p  = data_p[3];
  assign valid_0p = valid_p[0];
  assign valid_1p = valid_p[1];
  assign valid_2p = valid_p[2];
  assign valid_3p = valid_p[3];
  assign active   = active_q;
endmodule

// File: tb/tb_byte_unstriper.sv
// Scoreboard bench for byte_unstriper: stimulus pushes expected words,
// a negedge monitor pops and compares on every valid pulse.

module tb_byte_unstriper;
  logic       clk_f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_0p, data_1p, data_2p, data_3p;
  logic       valid_0p, valid_1p, valid_2p, valid_3p;
  logic       active;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;

  byte_unstriper dut (
    .clk_f    (clk_f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_0p  (data_0p),
    .data_1p  (data_1p),
    .data_2p  (data_2p),
    .data_3p  (data_3p),
    .valid_0p (valid_0p),
    .valid_1p (valid_1p),
    .valid_2p (valid_2p),
    .valid_3p (valid_3p),
    .active   (active)
  );

  always #5 clk_f = ~clk_f;

  function automatic logic [31:0] dout();
    return {data_3p, data_2p, data_1p, data_0p};
  endfunction

  function automatic logic [3:0] vout();
    return {valid_3p, valid_2p, valid_1p, valid_0p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] v);
    q.push_back(exp_t'{d: d, v: v});
  endtask

  // Present one cycle of input, return 2 time units after the sampling edge.
  task automatic drive(input logic v, input logic [7:0] b);
    valid_in = v;
    data_in  = b;
    @(posedge clk_f);
    #2;
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  always @(negedge clk_f) begin
    if (!reset && vout() != 4'h0) begin
      exp_t e;
      pulse_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_pulse", {28'h0, vout()}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("word_data", dout(), e.d);
        chk("word_valid", {28'h0, vout()}, {28'h0, e.v});
      end
    end
  end

  initial begin
    int pre;
    #1;
    chk("reset_data", dout(), 32'h0);
    chk("reset_valid", {28'h0, vout()}, 32'h0);
    chk("reset_active", {31'h0, active}, 32'h0);
    @(posedge clk_f); #2;
    reset = 1'b0;

    // Sync with a gap inside the COM run (gap holds the count), then one word.
    drive(1, 8'hBC); drive(1, 8'hBC); drive(0, 8'h00); drive(1, 8'hBC);
    chk("sync_3_com", {31'h0, active}, 32'h0);
    drive(1, 8'hBC);
    chk("sync_4_com", {31'h0, active}, 32'h1);
    push(32'h44332211, 4'hF);
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33); drive(1, 8'h44);
    chk("word1_latency", dout(), 32'h44332211);
    drive(0, 8'h00);

    // Idle fill at slot 0 is dropped, COM inside a word is kept.
    push(32'hDDCCBCAA, 4'hF);
    drive(1, 8'hBC); drive(1, 8'hBC); drive(1, 8'hAA);
    drive(0, 8'h00); drive(0, 8'h00); drive(0, 8'h00);
    drive(1, 8'hBC); drive(1, 8'hCC); drive(1, 8'hDD);
    drive(0, 8'h00); drive(0, 8'h00);
    chk("data_hold", dout(), 32'hDDCCBCAA);
    chk("still_active", {31'h0, active}, 32'h1);

    // Asynchronous reset in the middle of a word.
    drive(1, 8'hAA); drive(1, 8'hBB);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_data", dout(), 32'h0);
    chk("async_rst_active", {31'h0, active}, 32'h0);
    @(posedge clk_f); #2;
    reset = 1'b0;

    // Broken COM run must restart the count.
    pre = pulse_cnt;
    drive(1, 8'hBC); drive(1, 8'hBC); drive(1, 8'hBC); drive(1, 8'h7E);
    chk("broken_after_7e", {31'h0, active}, 32'h0);
    drive(1, 8'hBC); drive(1, 8'hBC); drive(1, 8'hBC);
    chk("broken_3_com", {31'h0, active}, 32'h0);
    chk("no_pulse_search", pulse_cnt, pre);
    drive(1, 8'hBC);
    chk("resync", {31'h0, active}, 32'h1);

    // Partial word followed by a long idle stretch.
`ifdef UNSTRIPE_TIMEOUT_EN
    push(32'h0000BBAA, 4'h3);
    drive(1, 8'hAA); drive(1, 8'hBB);
    for (int i = 0; i < 8; i++) drive(0, 8'h00);
    drive(0, 8'h00);
    chk("flush_hold", dout(), 32'h0000BBAA);
    push(32'h0201FFEE, 4'hF);
    drive(1, 8'hEE); drive(1, 8'hFF); drive(1, 8'h01); drive(1, 8'h02);
`else
    pre = pulse_cnt;
    drive(1, 8'hAA); drive(1, 8'hBB);
    for (int i = 0; i < 8; i++) drive(0, 8'h00);
    chk("no_timeout_pulse", pulse_cnt, pre);
    push(32'hDDCCBBAA, 4'hF);
    drive(1, 8'hCC); drive(1, 8'hDD);
`endif
    drive(0, 8'h00); drive(0, 8'h00); drive(0, 8'h00);
    chk("scoreboard_empty", q.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
